// File: rtl/sha256_msg_padder_if.sv
// Byte-in / padded-word-out handshake bundle for the SHA-256 message padder.
interface sha256_msg_padder_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_empty;
  logic        s_ready;
  logic [31:0] m_word;
  logic        m_valid;
  logic        m_ready;
  logic        m_first;
  logic        m_block_last;
  logic        m_msg_last;

  modport slave (
    input  s_data, s_valid, s_last, s_empty, m_ready,
    output s_ready, m_word, m_valid,
    output m_first, m_block_last, m_msg_last
  );

  modport master (
    output s_data, s_valid, s_last, s_empty, m_ready,
    input  s_ready, m_word, m_valid,
    input  m_first, m_block_last, m_msg_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs bytes into big-endian words, appends 0x80/zeros/length.
// SHA256_PAD_BLKCNT_EN adds the blk_cnt output (blocks handed off in this message).
module sha256_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  sha256_msg_padder_if.slave bus,
  output logic err_ovf
`ifdef SHA256_PAD_BLKCNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  typedef enum logic [1:0] {
    S_DATA,
    S_PAD80,
    S_ZERO,
    S_LEN
  } state_t;

  state_t             r_state;
  state_t             w_nx;
  logic               r_rdy;
  logic [5:0]         r_pos;
  logic [23:0]        r_asm;
  logic [LEN_W-1:0]   r_cnt;
  logic [2:0]         r_lidx;
  logic [31:0]        r_word;
  logic               r_valid;
  logic               r_first;
  logic               r_blast;
  logic               r_mlast;
  logic               r_ovf;

  logic               w_ok;
  logic               w_sready;
  logic               w_acc;
  logic               w_take;
  logic [7:0]         w_byte;
  logic [5:0]         w_pos_nx;
  logic [63:0]        w_len;
  logic [7:0]         w_lbyte;
  logic               w_hs;

  assign w_pos_nx = r_pos + 6'd1;
  assign w_len    = {{(61-LEN_W){1'b0}}, r_cnt, 3'b000};
  assign w_lbyte  = w_len[{~r_lidx, 3'b000} +: 8];
  assign w_hs     = r_valid && bus.m_ready;

  // Only the word-completing byte can collide with a held output word
  assign w_ok     = (r_pos[1:0] != 2'd3) || !r_valid || bus.m_ready;
  assign w_sready = r_rdy && (r_state == S_DATA) && w_ok;
  assign w_acc    = bus.s_valid && w_sready;

  always_comb begin
    w_nx   = r_state;
    w_take = 1'b0;
    w_byte = 8'h00;
    unique case (r_state)
      S_DATA: begin
        w_take = w_acc && !bus.s_empty;
        w_byte = bus.s_data;
        if (w_acc && bus.s_last) w_nx = S_PAD80;
      end
      S_PAD80: begin
        w_take = w_ok;
        w_byte = 8'h80;
        if (w_ok) w_nx = (w_pos_nx == 6'd56) ? S_LEN : S_ZERO;
      end
      S_ZERO: begin
        w_take = w_ok;
        if (w_ok && w_pos_nx == 6'd56) w_nx = S_LEN;
      end
      S_LEN: begin
        w_take = w_ok;
        w_byte = w_lbyte;
        if (w_ok && r_lidx == 3'd7) w_nx = S_DATA;
      end
      default: w_nx = S_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_DATA;
      r_rdy   <= 1'b0;
      r_pos   <= '0;
      r_asm   <= '0;
      r_cnt   <= '0;
      r_lidx  <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_blast <= 1'b0;
      r_mlast <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_rdy   <= 1'b1;
      r_state <= w_nx;
      if (w_hs) r_valid <= 1'b0;
      if (w_take) begin
        r_pos <= w_pos_nx;
        if (r_pos[1:0] == 2'd3) begin
          r_word  <= {r_asm, w_byte};
          r_valid <= 1'b1;
          r_first <= (r_pos[5:2] == 4'd0);
          r_blast <= (r_pos[5:2] == 4'd15);
          r_mlast <= (r_pos[5:2] == 4'd15) && (r_state == S_LEN);
        end else begin
          r_asm <= {r_asm[15:0], w_byte};
        end
      end
      // Saturate rather than wrap so the length field never shrinks
      if (w_take && r_state == S_DATA) begin
        if (&r_cnt) r_ovf <= 1'b1;
        else        r_cnt <= r_cnt + 1'b1;
      end
      if (w_take && r_state == S_LEN) begin
        r_lidx <= r_lidx + 3'd1;
        if (r_lidx == 3'd7) begin
          r_cnt <= '0;
          r_pos <= '0;
        end
      end
    end
  end

`ifdef SHA256_PAD_BLKCNT_EN
  logic [15:0] r_blk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blk <= '0;
    end else if (w_hs && r_blast) begin
      r_blk <= r_mlast ? 16'd0 : r_blk + 16'd1;
    end
  end

  assign blk_cnt = r_blk;
`endif

  assign bus.s_ready      = w_sready;
  assign bus.m_word       = r_word;
  assign bus.m_valid      = r_valid;
  assign bus.m_first      = r_first;
  assign bus.m_block_last = r_blast;
  assign bus.m_msg_last   = r_mlast;
  assign err_ovf          = r_ovf;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: FIPS padding vectors, backpressure, reset.
// Output entries are {first, block_last, msg_last, word}.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_ovf;
`ifdef SHA256_PAD_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  sha256_msg_padder_if bus();

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .err_ovf (err_ovf)
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    .blk_cnt (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  logic hold = 1'b0;
  logic bp = 1'b0;
  logic [34:0] rxq[$];
  logic [34:0] expq[$];
  logic [7:0]  msg[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    bus.m_ready = bp ? ($urandom_range(0, 1) != 0) : !hold;

  always @(negedge clk) begin
    #2;
    if (reset_n && bus.m_valid && bus.m_ready)
      rxq.push_back({bus.m_first, bus.m_block_last,
                     bus.m_msg_last, bus.m_word});
  end

  function automatic logic [34:0] rx(input int i);
    return (i < rxq.size()) ? rxq[i] : '1;
  endfunction

  task automatic model();
    logic [7:0]  b[$];
    logic [63:0] len;
    int nw;
    b = msg;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    len = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) b.push_back(len[8*i +: 8]);
    nw = b.size() / 4;
    expq.delete();
    for (int w = 0; w < nw; w++)
      expq.push_back({(w % 16 == 0), (w % 16 == 15), (w == nw - 1),
                      b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
  endtask

  task automatic send(input logic [7:0] d,
                      input logic last,
                      input logic empty);
    int t;
    t = 0;
    @(negedge clk);
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_empty = empty;
    bus.s_valid = 1'b1;
    #1;
    while (!bus.s_ready && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.s_ready) chk("send_timeout", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_empty = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n);
    int t;
    t = 0;
    while (rxq.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_nwords"}, 64'(rxq.size()), 64'(n));
  endtask

  task automatic compare(input string tag);
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(rx(i)), 64'(expq[i]));
`ifdef SHA256_PAD_BLKCNT_EN
    chk({tag, "_blkcnt"}, 64'(blk_cnt), 64'd0);
`endif
  endtask

  task automatic run_msg(input string tag, input logic empty_end);
    rxq.delete();
    model();
    for (int i = 0; i < msg.size(); i++)
      send(msg[i], !empty_end && (i == msg.size() - 1), 1'b0);
    if (empty_end) send(8'h00, 1'b1, 1'b1);
    idle();
    wait_words(tag, expq.size());
    compare(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_empty = 1'b0;
    #2;
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_word", 64'(bus.m_word), 64'd0);
    chk("rst_flags", 64'({bus.m_first, bus.m_block_last,
                          bus.m_msg_last}), 64'd0);
    chk("rst_err_ovf", 64'(err_ovf), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("rel_s_ready_pre", 64'(bus.s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_s_ready_post", 64'(bus.s_ready), 64'd1);

    msg = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", 1'b0);
    chk("abc_w0_hand", 64'(rx(0)), 64'({3'b100, 32'h61626380}));
    chk("abc_w15_hand", 64'(rx(15)), 64'({3'b011, 32'h00000018}));

    msg.delete();
    run_msg("empty", 1'b1);
    chk("empty_w0_hand", 64'(rx(0)), 64'({3'b100, 32'h80000000}));
    chk("empty_w15_hand", 64'(rx(15)), 64'({3'b011, 32'h00000000}));

    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'h00);
    run_msg("z55", 1'b0);
    chk("z55_w13_hand", 64'(rx(13)), 64'({3'b000, 32'h00000080}));
    chk("z55_w15_hand", 64'(rx(15)), 64'({3'b011, 32'h000001B8}));

    msg.push_back(8'h00);
    run_msg("z56", 1'b0);
    chk("z56_b0w14_hand", 64'(rx(14)), 64'({3'b000, 32'h80000000}));
    chk("z56_b0w15_hand", 64'(rx(15)), 64'({3'b010, 32'h00000000}));
    chk("z56_b1w15_hand", 64'(rx(31)), 64'({3'b011, 32'h000001C0}));

    hold = 1'b1;
    repeat (2) @(negedge clk);
    rxq.delete();
    msg = '{8'h61, 8'h62, 8'h63};
    model();
    send(8'h61, 1'b0, 1'b0);
    send(8'h62, 1'b0, 1'b0);
    send(8'h63, 1'b1, 1'b0);
    idle();
    repeat (20) @(negedge clk);
    #2;
    chk("stall_m_valid", 64'(bus.m_valid), 64'd1);
    chk("stall_m_word", 64'(bus.m_word), 64'h61626380);
    chk("stall_s_ready", 64'(bus.s_ready), 64'd0);
    chk("stall_nrx", 64'(rxq.size()), 64'd0);
    hold = 1'b0;
    wait_words("stall", expq.size());
    compare("stall");

    bp = 1'b1;
    msg.delete();
    for (int i = 0; i < 70; i++) msg.push_back(8'(i * 7 + 3));
    run_msg("bp70", 1'b0);
    bp = 1'b0;

    msg.delete();
    for (int i = 0; i < 10; i++) msg.push_back(8'h55);
    for (int i = 0; i < 10; i++) send(msg[i], 1'b0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #2;
    chk("mrst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("mrst_s_ready", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg("mrst_abc", 1'b0);
    chk("mrst_err_ovf", 64'(err_ovf), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
